// File: rtl/scroll_text_7seg.sv
// Scrolls a writable MSG_LEN-character message across NUM_DIGITS active-low 7-segment displays,
// stepping on a divided-clock tick (auto) or on Step rising edges (manual).
module scroll_text_7seg #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned MSG_LEN    = 8,
   parameter int unsigned TICK_DIV   = 25000000,
   parameter int unsigned CHAR_W     = 3
) (
   input  logic                       Clock,
   input  logic                       Resetn,
   input  logic                       En,
   input  logic                       Mode,
   input  logic                       Dir,
   input  logic                       Step,
   input  logic                       wr_en,
   input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
   input  logic [CHAR_W-1:0]          wr_data,
   output logic [8*NUM_DIGITS-1:0]    HEX,
   output logic [$clog2(MSG_LEN)-1:0] pos
);

   localparam int unsigned AW = $clog2(MSG_LEN);
   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned HW = 8 * NUM_DIGITS;

   typedef enum logic [1:0] {ST_STOP, ST_AUTO, ST_MANUAL} state_e;

   state_e              state_q, state_d;
   logic [TW-1:0]       cnt_q, cnt_d;
   logic [AW-1:0]       pos_q, pos_d;
   logic                step_q, step_d;
   logic [CHAR_W-1:0]   msg_q [MSG_LEN];
   logic [CHAR_W-1:0]   msg_d [MSG_LEN];
   logic [HW-1:0]       hex_q, hex_d;
   logic                step_c;
   logic                addr_ok_c;

   // Segment byte is {a,b,c,d,e,f,g,dp}, 0 = lit; dp always off.
   function automatic logic [7:0] seg_decode(input logic [CHAR_W-1:0] code);
      logic [7:0] seg;
      case (32'(code))
         0:       seg = 8'b1001000_1;
         1:       seg = 8'b0110000_1;
         2:       seg = 8'b1110001_1;
         3:       seg = 8'b0000001_1;
         4:       seg = 8'b1000010_1;
         5:       seg = 8'b0000001_1;
         6:       seg = 8'b1111110_1;
         default: seg = 8'b1111111_1;
      endcase
      return seg;
   endfunction

   // Out-of-range write addresses only exist when MSG_LEN is not a power of two.
   if ((1 << AW) > MSG_LEN) begin : g_addr_chk
      assign addr_ok_c = (32'(wr_addr) < MSG_LEN);
   end else begin : g_addr_full
      assign addr_ok_c = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      step_d  = Step;
      step_c  = 1'b0;

      if (!En)       state_d = ST_STOP;
      else if (Mode) state_d = ST_MANUAL;
      else           state_d = ST_AUTO;

      if (state_q == ST_MANUAL && state_d == ST_AUTO) begin
         cnt_d = '0;
      end else if (state_q == ST_AUTO) begin
         if (cnt_q == TW'(TICK_DIV - 1)) begin
            cnt_d  = '0;
            step_c = 1'b1;
         end else begin
            cnt_d = cnt_q + TW'(1);
         end
      end

      if (state_q == ST_MANUAL && Step && !step_q) step_c = 1'b1;

      if (step_c) begin
         if (!Dir) pos_d = (pos_q == AW'(MSG_LEN - 1)) ? '0 : pos_q + AW'(1);
         else      pos_d = (pos_q == '0) ? AW'(MSG_LEN - 1) : pos_q - AW'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < int'(MSG_LEN); i++) begin
         msg_d[i] = msg_q[i];
         if (wr_en && addr_ok_c && wr_addr == AW'(i)) msg_d[i] = wr_data;
      end
   end

   // Leftmost digit shows msg[pos]; display reads last cycle's pos and buffer.
   always_comb begin
      hex_d = '1;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         hex_d[8*k +: 8] = seg_decode(msg_q[AW'((32'(pos_q) + NUM_DIGITS - 1 - 32'(k)) % MSG_LEN)]);
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_STOP;
         cnt_q   <= '0;
         pos_q   <= '0;
         step_q  <= 1'b0;
         hex_q   <= '1;
         for (int i = 0; i < int'(MSG_LEN); i++) msg_q[i] <= CHAR_W'(7);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         step_q  <= step_d;
         hex_q   <= hex_d;
         for (int i = 0; i < int'(MSG_LEN); i++) msg_q[i] <= msg_d[i];
      end
   end

   assign HEX = hex_q;
   assign pos = pos_q;

endmodule
